// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: buttons, switches, ALU mux hookup and display outputs of the sequencer
interface alu_op_sequencer_if #(parameter int WIDTH = 8);
  logic             btn_go;
  logic             btn_clr;
  logic [WIDTH-1:0] sw_data;
  logic [3:0]       sw_op;
  logic [WIDTH-1:0] alu_y;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] result;
  logic [1:0]       state;
  logic             busy;
  logic             done;
  modport master (
    output btn_go, btn_clr, sw_data, sw_op, alu_y,
    input  alu_sel, reg_a, reg_b, result, state, busy, done
  );
  modport slave (
    input  btn_go, btn_clr, sw_data, sw_op, alu_y,
    output alu_sel, reg_a, reg_b, result, state, busy, done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: debounced operand load, op issue, result capture and write-back for the ALU
module alu_op_sequencer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic              clk,
  input logic              rst_n,
  alu_op_sequencer_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, READY, CAPTURE} state_t;
  state_t           st;
  logic [WIDTH-1:0] ra, rb, res;
  logic [3:0]       sel;
  logic             busy_q, done_q;
  logic [1:0]       btn_raw, pulse;
  logic             go_p, clr_p;
  assign btn_raw = {bus.btn_clr, bus.btn_go};
  assign go_p    = pulse[0];
  assign clr_p   = pulse[1];
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic          s1, s2, stable, p;
    logic [CW-1:0] cnt;
    assign pulse[i] = p;
    // synchronise the raw button, accept a level only after it holds long enough, pulse on press
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        stable <= 1'b0;
        cnt    <= '0;
        p      <= 1'b0;
      end else begin
        s1 <= btn_raw[i];
        s2 <= s1;
        p  <= 1'b0;
        if (s2 == stable) cnt <= '0;
        else if (cnt == LAST) begin
          stable <= s2;
          cnt    <= '0;
          p      <= s2;
        end else cnt <= cnt + 1'b1;
      end
  end
  // operand load, op issue and one-cycle capture with data-movement write-back
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st     <= LOAD_A;
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      sel    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clr_p) begin
        st     <= LOAD_A;
        ra     <= '0;
        rb     <= '0;
        res    <= '0;
        sel    <= '0;
        busy_q <= 1'b0;
      end else case (st)
        LOAD_A: if (go_p) begin
          ra <= bus.sw_data;
          st <= LOAD_B;
        end
        LOAD_B: if (go_p) begin
          rb <= bus.sw_data;
          st <= READY;
        end
        READY: if (go_p) begin
          sel    <= bus.sw_op;
          busy_q <= 1'b1;
          st     <= CAPTURE;
        end
        CAPTURE: begin
          res    <= bus.alu_y;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          st     <= READY;
          if (sel == 4'd13) ra <= bus.alu_y;
          else if (sel == 4'd14) begin
            ra <= rb;
            rb <= ra;
          end else if (sel == 4'd15) ra <= bus.sw_data;
        end
      endcase
    end
  assign bus.alu_sel = sel;
  assign bus.reg_a   = ra;
  assign bus.reg_b   = rb;
  assign bus.result  = res;
  assign bus.state   = st;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven op checks plus hand-written debounce, clear and reset sequences
module tb_alu_op_sequencer;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_op_sequencer_if #(.WIDTH(W)) bus ();
  alu_op_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] cap_a, cap_b, cap_r, cap_state;
  typedef struct {
    logic [3:0] op;
    logic [7:0] data;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] er;
  } vec_t;
  vec_t tbl[17];
  // reference operation mux
  always_comb begin
    case (bus.alu_sel)
      4'd0:    bus.alu_y = bus.reg_a + bus.reg_b;
      4'd1:    bus.alu_y = bus.reg_a - bus.reg_b;
      4'd2:    bus.alu_y = bus.reg_a << 1;
      4'd3:    bus.alu_y = bus.reg_a >> 1;
      4'd4:    bus.alu_y = {7'b0, bus.reg_a > bus.reg_b};
      4'd5:    bus.alu_y = bus.reg_a & bus.reg_b;
      4'd6:    bus.alu_y = bus.reg_a | bus.reg_b;
      4'd7:    bus.alu_y = bus.reg_a ^ bus.reg_b;
      4'd8:    bus.alu_y = ~(bus.reg_a & bus.reg_b);
      4'd9:    bus.alu_y = ~(bus.reg_a | bus.reg_b);
      4'd10:   bus.alu_y = ~(bus.reg_a ^ bus.reg_b);
      4'd11:   bus.alu_y = ~bus.reg_a;
      4'd12:   bus.alu_y = 8'd0 - bus.reg_a;
      4'd13:   bus.alu_y = bus.result;
      4'd14:   bus.alu_y = bus.reg_a;
      default: bus.alu_y = bus.sw_data;
    endcase
  end
  // record every cycle that done is high, with the values visible then
  always @(negedge clk)
    if (bus.done) begin
      done_cnt = done_cnt + 1;
      cap_a = bus.reg_a;
      cap_b = bus.reg_b;
      cap_r = bus.result;
      cap_state = 8'(bus.state);
    end
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic press(input bit go, input bit clr);
    @(negedge clk);
    bus.btn_go = go;
    bus.btn_clr = clr;
    repeat (10) @(negedge clk);
    bus.btn_go = 1'b0;
    bus.btn_clr = 1'b0;
    repeat (10) @(negedge clk);
  endtask
  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    bus.sw_data = a;
    press(1'b1, 1'b0);
    bus.sw_data = b;
    press(1'b1, 1'b0);
  endtask
  task automatic run_op(input vec_t v, input int idx);
    int n;
    string tag;
    tag = $sformatf("op%0d_row%0d", v.op, idx);
    n = done_cnt;
    bus.sw_op = v.op;
    bus.sw_data = v.data;
    press(1'b1, 1'b0);
    check({tag, "_done_pulses"}, 8'(done_cnt - n), 8'd1);
    check({tag, "_result"}, cap_r, v.er);
    check({tag, "_reg_a"}, cap_a, v.ea);
    check({tag, "_reg_b"}, cap_b, v.eb);
    check({tag, "_state"}, cap_state, 8'd2);
    check({tag, "_alu_sel"}, 8'(bus.alu_sel), 8'(v.op));
  endtask
  initial begin
    int lat;
    int n;
    bit found;
    tbl[0]  = '{4'd0,  8'h00, 8'h12, 8'h34, 8'h46};
    tbl[1]  = '{4'd13, 8'h00, 8'h46, 8'h34, 8'h46};
    tbl[2]  = '{4'd0,  8'h00, 8'h46, 8'h34, 8'h7A};
    tbl[3]  = '{4'd1,  8'h00, 8'h46, 8'h34, 8'h12};
    tbl[4]  = '{4'd5,  8'h00, 8'h46, 8'h34, 8'h04};
    tbl[5]  = '{4'd6,  8'h00, 8'h46, 8'h34, 8'h76};
    tbl[6]  = '{4'd7,  8'h00, 8'h46, 8'h34, 8'h72};
    tbl[7]  = '{4'd8,  8'h00, 8'h46, 8'h34, 8'hFB};
    tbl[8]  = '{4'd2,  8'h00, 8'h46, 8'h34, 8'h8C};
    tbl[9]  = '{4'd3,  8'h00, 8'h46, 8'h34, 8'h23};
    tbl[10] = '{4'd12, 8'h00, 8'h46, 8'h34, 8'hBA};
    tbl[11] = '{4'd11, 8'h00, 8'h46, 8'h34, 8'hB9};
    tbl[12] = '{4'd14, 8'h00, 8'h34, 8'h46, 8'h46};
    tbl[13] = '{4'd15, 8'hA5, 8'hA5, 8'h46, 8'hA5};
    tbl[14] = '{4'd4,  8'h00, 8'hA5, 8'h46, 8'h01};
    tbl[15] = '{4'd9,  8'h00, 8'hA5, 8'h46, 8'h18};
    tbl[16] = '{4'd10, 8'h00, 8'hA5, 8'h46, 8'h1C};
    bus.btn_go = 1'b0;
    bus.btn_clr = 1'b0;
    bus.sw_data = 8'h00;
    bus.sw_op = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_state", 8'(bus.state), 8'd0);
    check("reset_reg_a", bus.reg_a, 8'h00);
    check("reset_reg_b", bus.reg_b, 8'h00);
    check("reset_result", bus.result, 8'h00);
    check("reset_alu_sel", 8'(bus.alu_sel), 8'd0);
    check("reset_busy", 8'(bus.busy), 8'd0);
    check("reset_done", 8'(bus.done), 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // a 3-cycle glitch never survives a 4-cycle debounce
    bus.sw_data = 8'h99;
    bus.btn_go = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_go = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_no_load_state", 8'(bus.state), 8'd0);
    check("glitch_no_load_reg_a", bus.reg_a, 8'h00);
    // a held press loads A seven edges after the rise, exactly once
    bus.sw_data = 8'h12;
    bus.btn_go = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.state == 2'd1) begin
        lat = i;
        break;
      end
    end
    check("go_latency", 8'(lat), 8'd7);
    repeat (6) @(negedge clk);
    bus.btn_go = 1'b0;
    repeat (10) @(negedge clk);
    check("single_pulse_state", 8'(bus.state), 8'd1);
    check("load_a_value", bus.reg_a, 8'h12);
    bus.sw_data = 8'h34;
    press(1'b1, 1'b0);
    check("load_b_state", 8'(bus.state), 8'd2);
    check("load_b_value", bus.reg_b, 8'h34);
    check("load_no_done", 8'(done_cnt), 8'd0);
    for (int i = 0; i < 17; i++) run_op(tbl[i], i);
    // sw_op is only sampled at issue
    bus.sw_op = 4'd3;
    repeat (5) @(negedge clk);
    check("sw_op_ignored_outside_ready", 8'(bus.alu_sel), 8'd10);
    // clear returns to LOAD_A with everything zeroed
    press(1'b0, 1'b1);
    check("clr_state", 8'(bus.state), 8'd0);
    check("clr_reg_a", bus.reg_a, 8'h00);
    check("clr_result", bus.result, 8'h00);
    check("clr_alu_sel", 8'(bus.alu_sel), 8'd0);
    // swap exchanges A and B on the same edge
    load_ab(8'h0F, 8'hF0);
    run_op('{4'd14, 8'h00, 8'hF0, 8'h0F, 8'h0F}, 100);
    // clear and go completing together: clear wins, no capture
    n = done_cnt;
    bus.sw_op = 4'd0;
    @(negedge clk);
    bus.btn_go = 1'b1;
    bus.btn_clr = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_go = 1'b0;
    bus.btn_clr = 1'b0;
    repeat (10) @(negedge clk);
    check("clr_prio_no_done", 8'(done_cnt - n), 8'd0);
    check("clr_prio_state", 8'(bus.state), 8'd0);
    check("clr_prio_reg_a", bus.reg_a, 8'h00);
    check("clr_prio_reg_b", bus.reg_b, 8'h00);
    check("clr_prio_result", bus.result, 8'h00);
    // async reset in CAPTURE of a STO discards the write-back
    load_ab(8'h12, 8'h34);
    bus.sw_op = 4'd0;
    press(1'b1, 1'b0);
    bus.sw_op = 4'd13;
    n = done_cnt;
    @(negedge clk);
    bus.btn_go = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.state == 2'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("capture_reached", 8'(found), 8'd1);
    check("busy_in_capture", 8'(bus.busy), 8'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 8'(bus.state), 8'd0);
    check("async_rst_reg_a", bus.reg_a, 8'h00);
    check("async_rst_reg_b", bus.reg_b, 8'h00);
    check("async_rst_result", bus.result, 8'h00);
    check("async_rst_busy", 8'(bus.busy), 8'd0);
    bus.btn_go = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_reg_a", bus.reg_a, 8'h00);
    check("post_rst_no_done", 8'(done_cnt - n), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
